fc_layer_link: RTL and testbench

Inter-layer transfer stage between two `fc_layer` instances in an MLP top. It consumes the activation stream from layer N (`o_func_data` plus a valid strobe) and writes it sequentially into layer N+1's input buffer. When the buffer is full it pulses layer N+1's start. It back-pressures layer N through that layer's `i_next_busy` until layer N+1 has finished computing.

---
 rtl/fc_layer_link_if.sv | 40 ++++
 rtl/fc_layer_link.sv | 87 ++++++++
 tb/tb_fc_layer_link.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fc_layer_link_if.sv
// Handshake bundle between an upstream fc_layer, the link and the
// downstream fc_layer input buffer.
interface fc_layer_link_if #(
    parameter int datatype_size = 4,
    parameter int addr_w        = 10
);
    logic                     i_func_valid;
    logic [datatype_size-1:0] i_func_data;
    logic                     o_next_busy;
    logic                     o_ibuf_we;
    logic [datatype_size-1:0] o_ibuf_wr_data;
    logic [addr_w-1:0]        o_ibuf_addr;
    logic                     o_start;
    logic                     i_busy;
    logic                     o_drop;

    modport master (
        input  i_func_valid,
        input  i_func_data,
        input  i_busy,
        output o_next_busy,
        output o_ibuf_we,
        output o_ibuf_wr_data,
        output o_ibuf_addr,
        output o_start,
        output o_drop
    );

    modport slave (
        output i_func_valid,
        output i_func_data,
        output i_busy,
        input  o_next_busy,
        input  o_ibuf_we,
        input  o_ibuf_wr_data,
        input  o_ibuf_addr,
        input  o_start,
        input  o_drop
    );
endinterface

// File: rtl/fc_layer_link.sv
// Streams layer N activations into layer N+1's input buffer, starts
// layer N+1 when full and holds layer N off until it is done.
module fc_layer_link #(
    parameter int datatype_size = 4,
    parameter int input_size    = 784,
    parameter int addr_w        = $clog2(input_size)
) (
    input logic             clk,
    input logic             rst,
    fc_layer_link_if.master bus
);
    typedef enum logic [2:0] {
        FILL,
        LAST,
        START,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t                   state;
    logic [addr_w-1:0]        cnt;
    logic                     next_busy_q;
    logic                     we_q;
    logic [datatype_size-1:0] data_q;
    logic [addr_w-1:0]        addr_q;
    logic                     start_q;
    logic                     drop_q;

    logic accept;
    logic at_last;

    assign accept  = bus.i_func_valid && !next_busy_q;
    assign at_last = (cnt == addr_w'(input_size - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            cnt         <= '0;
            next_busy_q <= 1'b0;
            we_q        <= 1'b0;
            data_q      <= '0;
            addr_q      <= '0;
            start_q     <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            we_q    <= accept;
            drop_q  <= bus.i_func_valid && next_busy_q;
            start_q <= 1'b0;
            if (accept) begin
                addr_q <= cnt;
                data_q <= bus.i_func_data;
                cnt    <= at_last ? '0 : cnt + 1'b1;
            end
            unique case (state)
                FILL: begin
                    if (accept && at_last) begin
                        state       <= LAST;
                        next_busy_q <= 1'b1;
                    end
                end
                LAST: begin
                    state   <= START;
                    start_q <= 1'b1;
                end
                START: state <= WAIT_ACK;
                // a low i_busy here is just layer N+1 not having started yet
                WAIT_ACK: begin
                    if (bus.i_busy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!bus.i_busy) begin
                        state       <= FILL;
                        next_busy_q <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.o_next_busy    = next_busy_q;
    assign bus.o_ibuf_we      = we_q;
    assign bus.o_ibuf_wr_data = data_q;
    assign bus.o_ibuf_addr    = addr_q;
    assign bus.o_start        = start_q;
    assign bus.o_drop         = drop_q;
endmodule

// File: tb/tb_fc_layer_link.sv
// Bench for fc_layer_link: per-cycle vector table plus a write
// scoreboard and hand-written reset / back-to-back sequences.
module tb_fc_layer_link;
    localparam int DW = 4;
    localparam int IS = 4;
    localparam int AW = 2;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          b;
        logic          we;
        logic          nb;
        logic          st;
        logic          dr;
    } row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fc_layer_link_if #(.datatype_size(DW), .addr_w(AW)) bus();

    fc_layer_link #(
        .datatype_size(DW),
        .input_size(IS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int starts = 0;
    int writes = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW-1:0]    exp_addr = '0;
    row_t             tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [DW-1:0] d,
                       input logic b, input logic we, input logic nb,
                       input logic st, input logic dr);
        row_t r;
        r.v = v; r.d = d; r.b = b;
        r.we = we; r.nb = nb; r.st = st; r.dr = dr;
        tbl.push_back(r);
    endtask

    task automatic push_exp(input logic [DW-1:0] d);
        exp_q.push_back({exp_addr, d});
        exp_addr = exp_addr + 1'b1;
    endtask

    task automatic feed(input logic [DW-1:0] d);
        bus.i_func_valid = 1'b1;
        bus.i_func_data  = d;
        push_exp(d);
        @(negedge clk);
        bus.i_func_valid = 1'b0;
    endtask

    task automatic finish_vec(input string name);
        bit done;
        bus.i_func_valid = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_busy = 1'b1;
        repeat (3) @(negedge clk);
        bus.i_busy = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (!bus.o_next_busy) done = 1'b1;
        end
        chk({name, " release"}, 32'(done), 32'd1);
    endtask

    task automatic chk_zero(input string name);
        chk({name, " next_busy"}, 32'(bus.o_next_busy), 0);
        chk({name, " we"}, 32'(bus.o_ibuf_we), 0);
        chk({name, " data"}, 32'(bus.o_ibuf_wr_data), 0);
        chk({name, " addr"}, 32'(bus.o_ibuf_addr), 0);
        chk({name, " start"}, 32'(bus.o_start), 0);
        chk({name, " drop"}, 32'(bus.o_drop), 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_start) starts++;
            if (bus.o_ibuf_we) begin
                writes++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb unexpected write addr=%0d data=%0h",
                             bus.o_ibuf_addr, bus.o_ibuf_wr_data);
                end else begin
                    logic [AW+DW-1:0] e;
                    e = exp_q.pop_front();
                    chk("sb addr", 32'(bus.o_ibuf_addr), 32'(e[AW+DW-1:DW]));
                    chk("sb data", 32'(bus.o_ibuf_wr_data), 32'(e[DW-1:0]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s0;
        int w0;
        bus.i_func_valid = 1'b0;
        bus.i_func_data  = '0;
        bus.i_busy       = 1'b0;

        // vector 3,5,7,9; busy low 5, high 10 with a dropped 0xF, then low
        add(1, 4'd3, 0, 1, 0, 0, 0);
        add(1, 4'd5, 0, 1, 0, 0, 0);
        add(1, 4'd7, 0, 1, 0, 0, 0);
        add(1, 4'd9, 0, 1, 1, 0, 0);
        add(0, 4'd0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 4'd0, 0, 0, 1, 0, 0);
        add(0, 4'd0, 1, 0, 1, 0, 0);
        add(0, 4'd0, 1, 0, 1, 0, 0);
        add(1, 4'hF, 1, 0, 1, 0, 1);
        for (int i = 0; i < 7; i++) add(0, 4'd0, 1, 0, 1, 0, 0);
        add(0, 4'd0, 0, 0, 0, 0, 0);
        // gapped vector 1,_,2,_,_,3,4
        add(1, 4'd1, 0, 1, 0, 0, 0);
        add(0, 4'd0, 0, 0, 0, 0, 0);
        add(1, 4'd2, 0, 1, 0, 0, 0);
        add(0, 4'd0, 0, 0, 0, 0, 0);
        add(0, 4'd0, 0, 0, 0, 0, 0);
        add(1, 4'd3, 0, 1, 0, 0, 0);
        add(1, 4'd4, 0, 1, 1, 0, 0);
        add(0, 4'd0, 0, 0, 1, 1, 0);
        add(0, 4'd0, 1, 0, 1, 0, 0);
        add(0, 4'd0, 1, 0, 1, 0, 0);
        add(0, 4'd0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        s0 = starts;
        for (int i = 0; i < tbl.size(); i++) begin
            bus.i_func_valid = tbl[i].v;
            bus.i_func_data  = tbl[i].d;
            bus.i_busy       = tbl[i].b;
            if (tbl[i].we) push_exp(tbl[i].d);
            @(negedge clk);
            chk($sformatf("row%0d we", i), 32'(bus.o_ibuf_we), 32'(tbl[i].we));
            chk($sformatf("row%0d next_busy", i), 32'(bus.o_next_busy),
                32'(tbl[i].nb));
            chk($sformatf("row%0d start", i), 32'(bus.o_start), 32'(tbl[i].st));
            chk($sformatf("row%0d drop", i), 32'(bus.o_drop), 32'(tbl[i].dr));
        end
        chk("table starts", 32'(starts - s0), 32'd2);

        // reset after two of four elements
        feed(4'd6);
        feed(4'd7);
        #2 rst = 1'b1;
        #1 chk_zero("midreset");
        exp_q.delete();
        exp_addr = '0;
        @(negedge clk);
        rst = 1'b0;
        s0 = starts;
        feed(4'd8);
        feed(4'd9);
        feed(4'd10);
        feed(4'd11);
        finish_vec("postreset");
        chk("postreset starts", 32'(starts - s0), 32'd1);

        // two vectors back to back
        s0 = starts;
        w0 = writes;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) feed(DW'(k * 4 + j + 1));
            finish_vec($sformatf("b2b%0d", k));
        end
        chk("b2b writes", 32'(writes - w0), 32'd8);
        chk("b2b starts", 32'(starts - s0), 32'd2);

        repeat (2) @(negedge clk);
        chk("sb drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
